out_seq_cmd: RTL and testbench

OUT_SEQ_CMD -- requirements
Module: out_seq_cmd

---
 rtl/out_seq_cmd_if.sv | 30 +++
 rtl/out_seq_cmd.sv | 188 ++++++++++++++++++
 tb/tb_out_seq_cmd.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/out_seq_cmd_if.sv
// Stream bundle for out_seq_cmd: task strobe, payload sink,
// response strobe and command source, with driver/DUT modports.
interface out_seq_cmd_if;
  logic        task_valid;
  logic [31:0] len_bytes;
  logic        asi_pay_valid;
  logic        asi_pay_ready;
  logic [31:0] asi_pay_data;
  logic        resp_valid;
  logic [31:0] resp;
  logic        aso_cmd_ready;
  logic        aso_cmd_valid;
  logic [31:0] aso_cmd_data;

  modport master (
    output task_valid, len_bytes,
    output asi_pay_valid, asi_pay_data,
    output aso_cmd_ready,
    input  asi_pay_ready, resp_valid, resp,
    input  aso_cmd_valid, aso_cmd_data
  );

  modport slave (
    input  task_valid, len_bytes,
    input  asi_pay_valid, asi_pay_data,
    input  aso_cmd_ready,
    output asi_pay_ready, resp_valid, resp,
    output aso_cmd_valid, aso_cmd_data
  );
endinterface

// File: rtl/out_seq_cmd.sv
// Strobe-task sequencer: checks a task header, buffers N strobe
// words, then streams one command word per entry.
// Ports: clk, rst (async, high), bus (out_seq_cmd_if.slave).
package task_icd_pkg;
  localparam int HEADER_WORDS = 2;
  localparam logic [31:0] TASK_VALID      = 32'd0;
  localparam logic [31:0] HEADER_INVALID  = 32'd1;
  localparam logic [31:0] PAYLOAD_INVALID = 32'd2;
  localparam logic [31:0] EXE_ERROR       = 32'd3;
endpackage

package cmd_icd_pkg;
  function automatic logic [31:0] task2out_cmd(
    input logic [4:0] s
  );
    return {16'hC500, 11'd0, s};
  endfunction
endpackage

module out_seq_cmd #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] TIMEOUT    = 32'd1000,
  parameter int          STROBE_MAX = 31
) (
  input logic          clk,
  input logic          rst,
  out_seq_cmd_if.slave bus
);
  import task_icd_pkg::*;
  import cmd_icd_pkg::*;

  localparam int IW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW0 = $clog2(33'(TIMEOUT) + 33'd1);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;
  localparam int HB  = 4 * HEADER_WORDS;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SRC   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]    r_state;
  logic [31:0]   r_len;
  logic [IW-1:0] r_n;
  logic [IW-1:0] r_k;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_cmd_valid;
  logic [31:0]   r_cmd_data;
  logic          r_resp_valid;
  logic [31:0]   r_resp;
  logic [4:0]    r_buf [DEPTH];

  logic          w_pay_rdy;
  logic          w_pay_hs;
  logic          w_cmd_hs;
  logic          w_tmo;
  logic [31:0]   w_nfull;
  logic          w_bad_hdr;
  logic          w_bad_word;
  logic          w_last_k;
  logic          w_last_idx;
  logic [IW-1:0] w_nxt_idx;
  logic [4:0]    w_first;

  assign w_pay_rdy  = (r_state == LOAD);
  assign w_pay_hs   = w_pay_rdy && bus.asi_pay_valid;
  assign w_cmd_hs   = r_cmd_valid && bus.aso_cmd_ready;
  assign w_tmo      = (r_cnt == CW'(TIMEOUT));
  assign w_nfull    = (r_len - 32'(HB)) >> 2;
  assign w_bad_hdr  = (|r_len[1:0])
                   || (r_len < 32'(HB + 4))
                   || (w_nfull > 32'(DEPTH));
  assign w_bad_word = bus.asi_pay_data > 32'(STROBE_MAX);
  assign w_last_k   = (r_k == r_n - 1'b1);
  assign w_last_idx = (r_idx == r_n - 1'b1);
  assign w_nxt_idx  = r_idx + 1'b1;
  // Slot 0 is written on the same edge when N == 1.
  assign w_first    = (r_k == '0) ? bus.asi_pay_data[4:0]
                                  : r_buf[0];

  assign bus.asi_pay_ready = w_pay_rdy;
  assign bus.aso_cmd_valid = r_cmd_valid;
  assign bus.aso_cmd_data  = r_cmd_data;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp          = r_resp;

  always_ff @(posedge clk) begin
    if (w_pay_hs) begin
      r_buf[r_k[AW-1:0]] <= bus.asi_pay_data[4:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_data   <= '0;
      r_resp_valid <= 1'b0;
      r_resp       <= TASK_VALID;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.task_valid) begin
            r_len   <= bus.len_bytes;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_bad_hdr) begin
            r_resp_valid <= 1'b1;
            r_resp       <= HEADER_INVALID;
            r_state      <= RESP;
          end else begin
            r_n     <= w_nfull[IW-1:0];
            r_k     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_pay_hs) begin
            r_cnt <= '0;
            if (w_bad_word) r_err <= 1'b1;
            if (!w_last_k) begin
              r_k <= r_k + 1'b1;
            end else if (r_err || w_bad_word) begin
              r_resp_valid <= 1'b1;
              r_resp       <= PAYLOAD_INVALID;
              r_state      <= RESP;
            end else begin
              r_idx       <= '0;
              r_cmd_valid <= 1'b1;
              r_cmd_data  <= task2out_cmd(w_first);
              r_state     <= SRC;
            end
          end else if (w_tmo) begin
            r_resp_valid <= 1'b1;
            r_resp       <= EXE_ERROR;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SRC: begin
          if (w_cmd_hs) begin
            r_cnt <= '0;
            if (w_last_idx) begin
              r_cmd_valid  <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp       <= TASK_VALID;
              r_state      <= RESP;
            end else begin
              r_idx      <= w_nxt_idx;
              r_cmd_data <= task2out_cmd(
                r_buf[w_nxt_idx[AW-1:0]]);
            end
          end else if (w_tmo) begin
            r_cmd_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp       <= EXE_ERROR;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_cmd_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_out_seq_cmd.sv
// Directed bench for out_seq_cmd: vector table plus
// timeout, back-pressure and reset sequences.
module tb_out_seq_cmd;
  localparam int TMO = 20;
  localparam logic [31:0] R_OK  = 32'd0;
  localparam logic [31:0] R_HDR = 32'd1;
  localparam logic [31:0] R_PAY = 32'd2;
  localparam logic [31:0] R_EXE = 32'd3;

  typedef struct {
    string            nm;
    logic [31:0]      len;
    int               nw;
    logic [7:0][31:0] w;
    logic [31:0]      rsp;
    int               nb;
    logic [7:0][31:0] d;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  out_seq_cmd_if bus ();

  out_seq_cmd #(
    .DEPTH(8),
    .TIMEOUT(32'(TMO)),
    .STROBE_MAX(31)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] beats[$];
  int          beat_cyc[$];
  logic [31:0] resps[$];
  int pay_hs = 0;
  int vcyc   = 0;
  int rcyc   = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  vec_t v[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && bus.aso_cmd_valid)
        chk("hold_data", bus.aso_cmd_data, prev_data);
      prev_stall = bus.aso_cmd_valid && !bus.aso_cmd_ready;
      prev_data  = bus.aso_cmd_data;
      if (bus.aso_cmd_valid && bus.aso_cmd_ready) begin
        beats.push_back(bus.aso_cmd_data);
        beat_cyc.push_back(cyc);
      end
      if (bus.asi_pay_valid && bus.asi_pay_ready) pay_hs++;
      if (bus.aso_cmd_valid) vcyc++;
      if (bus.asi_pay_ready) rcyc++;
      if (bus.resp_valid) resps.push_back(bus.resp);
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    beats.delete();
    beat_cyc.delete();
    resps.delete();
    pay_hs = 0;
    vcyc   = 0;
    rcyc   = 0;
  endtask

  task automatic start(input logic [31:0] len);
    bus.task_valid = 1'b1;
    bus.len_bytes  = len;
    step();
    bus.task_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    bus.asi_pay_valid = 1'b1;
    bus.asi_pay_data  = w;
    @(negedge clk);
    while (!bus.asi_pay_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL pay_wait: ready %b required 1",
               bus.asi_pay_ready);
    end
    step();
    bus.asi_pay_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int t = 0;
    while (resps.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    step();
    repeat (3) step();
  endtask

  task automatic chk_beats(input string nm, input int nb,
                           input logic [7:0][31:0] d);
    chk({nm, "_nbeats"}, beats.size(), nb);
    for (int i = 0; i < nb; i++)
      if (i < beats.size())
        chk({nm, "_data"}, beats[i], d[i]);
    if (nb > 1 && beats.size() == nb)
      chk({nm, "_b2b"}, beat_cyc[nb-1] - beat_cyc[0], nb - 1);
  endtask

  task automatic chk_resp(input string nm,
                          input logic [31:0] rsp);
    chk({nm, "_nresp"}, resps.size(), 1);
    if (resps.size() > 0) chk({nm, "_resp"}, resps[0], rsp);
  endtask

  task automatic run_vec(input vec_t t);
    clr();
    start(t.len);
    if (t.rsp == R_HDR) begin
      bus.asi_pay_valid = 1'b1;
      wait_resp();
      bus.asi_pay_valid = 1'b0;
    end else begin
      for (int i = 0; i < t.nw; i++) send_word(t.w[i]);
      wait_resp();
    end
    chk_resp(t.nm, t.rsp);
    chk({t.nm, "_payhs"}, pay_hs, t.nw);
    chk_beats(t.nm, t.nb, t.d);
  endtask

  function automatic vec_t mk(input string nm,
                              input logic [31:0] len,
                              input int nw,
                              input logic [31:0] rsp,
                              input int nb);
    vec_t r;
    r.nm  = nm;
    r.len = len;
    r.nw  = nw;
    r.w   = '0;
    r.rsp = rsp;
    r.nb  = nb;
    r.d   = '0;
    return r;
  endfunction

  logic [7:0][31:0] dx;
  logic stalled;

  initial begin
    bus.task_valid    = 1'b0;
    bus.len_bytes     = '0;
    bus.asi_pay_valid = 1'b0;
    bus.asi_pay_data  = '0;
    bus.aso_cmd_ready = 1'b1;
    dx = '0;

    v[0] = mk("basic3", 32'd20, 3, R_OK, 3);
    v[0].w[0] = 32'd0;
    v[0].w[1] = 32'd5;
    v[0].w[2] = 32'd31;
    v[0].d[0] = 32'hC500_0000;
    v[0].d[1] = 32'hC500_0005;
    v[0].d[2] = 32'hC500_001F;
    v[1] = mk("hdr_mod", 32'd14, 0, R_HDR, 0);
    v[2] = mk("hdr_big", 32'd44, 0, R_HDR, 0);
    v[3] = mk("hdr_short", 32'd8, 0, R_HDR, 0);
    v[4] = mk("pay_bad", 32'd16, 2, R_PAY, 0);
    v[4].w[0] = 32'd7;
    v[4].w[1] = 32'd32;
    v[5] = mk("full8", 32'd40, 8, R_OK, 8);
    v[5].w[0] = 32'd1;
    v[5].w[1] = 32'd2;
    v[5].w[2] = 32'd4;
    v[5].w[3] = 32'd8;
    v[5].w[4] = 32'd16;
    v[5].w[5] = 32'd30;
    v[5].w[6] = 32'd31;
    v[5].w[7] = 32'd0;
    v[5].d[0] = 32'hC500_0001;
    v[5].d[1] = 32'hC500_0002;
    v[5].d[2] = 32'hC500_0004;
    v[5].d[3] = 32'hC500_0008;
    v[5].d[4] = 32'hC500_0010;
    v[5].d[5] = 32'hC500_001E;
    v[5].d[6] = 32'hC500_001F;
    v[5].d[7] = 32'hC500_0000;
    v[6] = mk("one", 32'd12, 1, R_OK, 1);
    v[6].w[0] = 32'd31;
    v[6].d[0] = 32'hC500_001F;
    v[7] = mk("pay_hi", 32'd12, 1, R_PAY, 0);
    v[7].w[0] = 32'hFFFF_FFFF;

    repeat (2) step();
    chk("rst_cmd_valid", bus.aso_cmd_valid, 0);
    chk("rst_pay_ready", bus.asi_pay_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp", bus.resp, R_OK);
    rst = 1'b0;
    step();

    foreach (v[i]) run_vec(v[i]);

    // Toggling ready with a TIMEOUT-1 stall after beat 2.
    clr();
    bus.aso_cmd_ready = 1'b0;
    stalled = 1'b0;
    start(32'd24);
    fork
      begin
        send_word(32'd9);
        send_word(32'd10);
        send_word(32'd11);
        send_word(32'd12);
      end
      begin
        for (int t = 0; t < 400 && resps.size() == 0; t++) begin
          step();
          if (beats.size() == 2 && !stalled) begin
            bus.aso_cmd_ready = 1'b0;
            repeat (TMO - 2) step();
            stalled = 1'b1;
          end else begin
            bus.aso_cmd_ready = ~bus.aso_cmd_ready;
          end
        end
      end
    join
    bus.aso_cmd_ready = 1'b1;
    wait_resp();
    chk_resp("toggle", R_OK);
    dx[0] = 32'hC500_0009;
    dx[1] = 32'hC500_000A;
    dx[2] = 32'hC500_000B;
    dx[3] = 32'hC500_000C;
    chk("toggle_nbeats", beats.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < beats.size()) chk("toggle_data", beats[i], dx[i]);

    // Handshake on the very cycle the counter hits TIMEOUT.
    clr();
    bus.aso_cmd_ready = 1'b0;
    start(32'd12);
    send_word(32'd4);
    repeat (TMO) step();
    bus.aso_cmd_ready = 1'b1;
    wait_resp();
    chk_resp("hs_wins", R_OK);
    chk("hs_wins_vcyc", vcyc, TMO + 1);
    dx = '0;
    dx[0] = 32'hC500_0004;
    chk_beats("hs_wins", 1, dx);

    // SRC timeout with ready held low.
    clr();
    bus.aso_cmd_ready = 1'b0;
    start(32'd12);
    send_word(32'd3);
    wait_resp();
    chk_resp("tmo_src", R_EXE);
    chk("tmo_src_vcyc", vcyc, TMO + 1);
    chk("tmo_src_nbeats", beats.size(), 0);
    chk("tmo_src_valid", bus.aso_cmd_valid, 0);
    bus.aso_cmd_ready = 1'b1;

    // LOAD timeout with no payload offered.
    clr();
    start(32'd16);
    wait_resp();
    chk_resp("tmo_load", R_EXE);
    chk("tmo_load_rcyc", rcyc, TMO + 1);
    chk("tmo_load_ready", bus.asi_pay_ready, 0);

    // Reset after 2 of 4 payload words.
    clr();
    start(32'd24);
    send_word(32'd9);
    send_word(32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_cmd_valid", bus.aso_cmd_valid, 0);
    chk("mrst_pay_ready", bus.asi_pay_ready, 0);
    chk("mrst_resp_valid", bus.resp_valid, 0);
    chk("mrst_resp", bus.resp, R_OK);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    chk("mrst_nresp", resps.size(), 0);
    clr();
    start(32'd12);
    send_word(32'd17);
    wait_resp();
    chk_resp("after_rst", R_OK);
    dx[0] = 32'hC500_0011;
    chk_beats("after_rst", 1, dx);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
